// File: rtl/id_ex_pipe_reg_if.sv
// rtl/id_ex_pipe_reg_if.sv - ID/EX pipeline register handshake and data bundle
//
// Purpose: groups every non-clock/reset signal of id_ex_pipe_reg.
//   The master modport is the environment side (ID stage plus EX stage).
//   The slave modport is the pipeline register itself.
// Signals:
//   flush                  taken-branch flush from EX/control
//   in_valid / in_ready    ID -> register handshake
//   in_pc, in_rt, in_rd, in_imm, in_bus_a, in_bus_b, in_ctrl   ID payload
//   out_valid / out_ready  register -> EX handshake
//   out_pc, out_rt, out_rd, out_imm, out_bus_a, out_bus_b, out_ctrl  EX payload
//   stall_cnt, bubble_cnt, flush_cnt   performance counters
interface id_ex_pipe_reg_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int IMM_W  = 16,
  parameter int CTRL_W = 11,
  parameter int CNT_W  = 16
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_pc;
  logic [REG_W-1:0]  in_rt;
  logic [REG_W-1:0]  in_rd;
  logic [IMM_W-1:0]  in_imm;
  logic [DATA_W-1:0] in_bus_a;
  logic [DATA_W-1:0] in_bus_b;
  logic [CTRL_W-1:0] in_ctrl;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_pc;
  logic [REG_W-1:0]  out_rt;
  logic [REG_W-1:0]  out_rd;
  logic [IMM_W-1:0]  out_imm;
  logic [DATA_W-1:0] out_bus_a;
  logic [DATA_W-1:0] out_bus_b;
  logic [CTRL_W-1:0] out_ctrl;

  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  bubble_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output flush, in_valid, in_pc, in_rt, in_rd, in_imm, in_bus_a, in_bus_b, in_ctrl,
    output out_ready,
    input  in_ready,
    input  out_valid, out_pc, out_rt, out_rd, out_imm, out_bus_a, out_bus_b, out_ctrl,
    input  stall_cnt, bubble_cnt, flush_cnt
  );

  modport slave (
    input  flush, in_valid, in_pc, in_rt, in_rd, in_imm, in_bus_a, in_bus_b, in_ctrl,
    input  out_ready,
    output in_ready,
    output out_valid, out_pc, out_rt, out_rd, out_imm, out_bus_a, out_bus_b, out_ctrl,
    output stall_cnt, bubble_cnt, flush_cnt
  );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// rtl/id_ex_pipe_reg.sv - two-entry skid-buffered ID/EX pipeline register
//
// Purpose: carries PC, Rt/Rd, immediate, both register-file read buses and
//   the packed control word from decode to execute with valid/ready flow
//   control, taken-branch flush and bubble masking of side-effect controls.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   id_ex_pipe_reg_if.slave (handshakes, payloads, perf counters)
// Optional feature macro: ID_EX_PERF_CNT_EN enables the saturating
//   stall/bubble/flush counters; when undefined they read as zero.
// Control word map: [0] ExtOp, [1] ALUSrc, [4:2] ALUop, [5] RegDst,
//   [6] R_type, [7] MemWr, [8] Branch, [9] MemtoReg, [10] RegWr.
module id_ex_pipe_reg #(
  parameter int                DATA_W    = 32,
  parameter int                REG_W     = 5,
  parameter int                IMM_W     = 16,
  parameter int                CTRL_W    = 11,
  parameter logic [CTRL_W-1:0] KILL_MASK = 11'h580,
  parameter int                CNT_W     = 16
) (
  input logic            clk,
  input logic            rst,
  id_ex_pipe_reg_if.slave bus
);

  localparam int ENTRY_W = 3 * DATA_W + 2 * REG_W + IMM_W + CTRL_W;

  // Occupancy: EMPTY (M0,S0), ONE (M1,S0), FULL (M1,S1).
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [ENTRY_W-1:0] r_m_entry;
  logic [ENTRY_W-1:0] r_s_entry;
  logic [ENTRY_W-1:0] w_in_entry;
  logic [CTRL_W-1:0]  w_m_ctrl;

  logic w_m_valid;
  logic w_s_valid;
  logic w_in_fire;
  logic w_out_fire;
  logic w_load_m_in;
  logic w_load_m_s;
  logic w_load_s_in;

  assign w_m_valid = (r_state != ST_EMPTY);
  assign w_s_valid = (r_state == ST_FULL);

  // in_ready comes only from state (plus reset), never from out_ready,
  // so back-pressure from EX never ripples combinationally into ID.
  assign bus.in_ready = rst | ~w_s_valid;

  assign w_in_fire  = bus.in_valid & ~w_s_valid & ~bus.flush;
  assign w_out_fire = w_m_valid & bus.out_ready;

  assign w_in_entry = {bus.in_pc, bus.in_rt, bus.in_rd, bus.in_imm,
                       bus.in_bus_a, bus.in_bus_b, bus.in_ctrl};

  // --------------------------------------------------------------------------
  // Occupancy FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load_m_in = 1'b0;
    w_load_m_s  = 1'b0;
    w_load_s_in = 1'b0;
    if (bus.flush) begin
      // Valid flags drop; payload registers are left untouched.
      w_state_nxt = ST_EMPTY;
    end else begin
      unique case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            w_load_m_in = 1'b1;
            w_state_nxt = ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_load_m_in = 1'b1;
          end else if (w_in_fire) begin
            w_load_s_in = 1'b1;
            w_state_nxt = ST_FULL;
          end else if (w_out_fire) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_out_fire) begin
            w_load_m_s  = 1'b1;
            w_state_nxt = ST_ONE;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Payload storage
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_m_entry <= '0;
      r_s_entry <= '0;
    end else begin
      if (w_load_m_in) begin
        r_m_entry <= w_in_entry;
      end else if (w_load_m_s) begin
        r_m_entry <= r_s_entry;
      end
      if (w_load_s_in) begin
        r_s_entry <= w_in_entry;
      end
    end
  end

  assign {bus.out_pc, bus.out_rt, bus.out_rd, bus.out_imm,
          bus.out_bus_a, bus.out_bus_b, w_m_ctrl} = r_m_entry;

  assign bus.out_valid = w_m_valid;

  // A bubble must not write registers, memory or redirect the PC, so the
  // side-effect bits are forced low whenever M holds no live instruction.
  assign bus.out_ctrl = w_m_valid ? w_m_ctrl : (w_m_ctrl & ~KILL_MASK);

  // --------------------------------------------------------------------------
  // Performance counters
  // --------------------------------------------------------------------------
`ifdef ID_EX_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_bubble_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // Counters stop at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
      r_flush_cnt  <= '0;
    end else begin
      if (w_m_valid && !bus.out_ready && !(&r_stall_cnt)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (!w_m_valid && !(&r_bubble_cnt)) begin
        r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
      end
      if (bus.flush && (w_m_valid || w_s_valid) && !(&r_flush_cnt)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.stall_cnt  = r_stall_cnt;
  assign bus.bubble_cnt = r_bubble_cnt;
  assign bus.flush_cnt  = r_flush_cnt;
`else
  assign bus.stall_cnt  = {CNT_W{1'b0}};
  assign bus.bubble_cnt = {CNT_W{1'b0}};
  assign bus.flush_cnt  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb/tb_id_ex_pipe_reg.sv - self-checking bench for id_ex_pipe_reg
module tb_id_ex_pipe_reg;

  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;
  localparam logic [10:0] KILL = 11'h580;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [31:0] a;
    logic [31:0] b;
    logic [10:0] ctrl;
  } entry_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  // Reference model: in-order FIFO of at most two live instructions.
  entry_t q[$];
  entry_t last_m;
  int     m_stall;
  int     m_bubble;
  int     m_flush;

  id_ex_pipe_reg_if #(.CNT_W(CNT_W)) bus ();

  id_ex_pipe_reg #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic int cnt_exp(input int v);
`ifdef ID_EX_PERF_CNT_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  function automatic entry_t rand_entry(input logic [31:0] pc);
    entry_t e;
    e.pc   = pc;
    e.rt   = 5'($urandom);
    e.rd   = 5'($urandom);
    e.imm  = 16'($urandom);
    e.a    = $urandom;
    e.b    = $urandom;
    e.ctrl = 11'($urandom);
    return e;
  endfunction

  task automatic drive(input logic v, input entry_t e);
    bus.in_valid = v;
    bus.in_pc    = e.pc;
    bus.in_rt    = e.rt;
    bus.in_rd    = e.rd;
    bus.in_imm   = e.imm;
    bus.in_bus_a = e.a;
    bus.in_bus_b = e.b;
    bus.in_ctrl  = e.ctrl;
  endtask

  function automatic entry_t observed();
    return {bus.out_pc, bus.out_rt, bus.out_rd, bus.out_imm,
            bus.out_bus_a, bus.out_bus_b, bus.out_ctrl};
  endfunction

  function automatic entry_t expected();
    entry_t e;
    if (q.size() > 0) begin
      e = q[0];
    end else begin
      e = last_m;
      e.ctrl = e.ctrl & ~KILL;
    end
    return e;
  endfunction

  // One clock: model advances on the same edge as the DUT; returns at negedge.
  task automatic cycle();
    logic   in_fire;
    logic   out_fire;
    entry_t cur;
    cur      = {bus.in_pc, bus.in_rt, bus.in_rd, bus.in_imm, bus.in_bus_a, bus.in_bus_b, bus.in_ctrl};
    in_fire  = !rst && bus.in_valid && (q.size() < 2) && !bus.flush;
    out_fire = (q.size() > 0) && bus.out_ready;
    if (!rst) begin
      if (q.size() > 0 && !bus.out_ready && m_stall < CMAX) m_stall++;
      if (q.size() == 0 && m_bubble < CMAX) m_bubble++;
      if (bus.flush && q.size() > 0 && m_flush < CMAX) m_flush++;
    end
    @(posedge clk);
    if (rst) begin
      q.delete();
      last_m   = '0;
      m_stall  = 0;
      m_bubble = 0;
      m_flush  = 0;
    end else if (bus.flush) begin
      q.delete();
    end else begin
      if (out_fire) void'(q.pop_front());
      if (in_fire) q.push_back(cur);
    end
    if (q.size() > 0) last_m = q[0];
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b1, rand_entry(32'h123));
    cycle();
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_during: got %b want 1", bus.in_ready); end
    cycle();
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    checks++;
    if (bus.out_ctrl !== 11'h0) begin errors++; $display("FAIL reset_out_ctrl: got %h want 0", bus.out_ctrl); end
    checks++;
    if (observed() !== entry_t'(0)) begin errors++; $display("FAIL reset_out_fields: got %h want 0", observed()); end
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    checks++;
    if ({bus.stall_cnt, bus.bubble_cnt, bus.flush_cnt} !== 12'h0) begin
      errors++; $display("FAIL reset_counters: got %h want 0", {bus.stall_cnt, bus.bubble_cnt, bus.flush_cnt});
    end
    rst = 1'b0;
    drive(1'b1, rand_entry(32'h0000_0004));
    cycle();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h4) begin
      errors++; $display("FAIL reset_first_accept: got valid=%b pc=%h want valid=1 pc=00000004", bus.out_valid, bus.out_pc);
    end
    checks++;
    if (bus.bubble_cnt !== CNT_W'(cnt_exp(m_bubble))) begin
      errors++; $display("FAIL reset_bubble_cnt: got %0d want %0d", bus.bubble_cnt, cnt_exp(m_bubble));
    end
  endtask

  task automatic test_streaming();
    drive(1'b0, '0);
    bus.out_ready = 1'b1;
    cycle();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, rand_entry(32'(i * 4)));
      cycle();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(i * 4) || bus.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL stream_%0d: got valid=%b pc=%h in_ready=%b want 1 %h 1", i, bus.out_valid, bus.out_pc, bus.in_ready, 32'(i * 4));
      end
      checks++;
      if (observed() !== expected()) begin errors++; $display("FAIL stream_payload_%0d: got %h want %h", i, observed(), expected()); end
    end
    drive(1'b0, '0);
    cycle();
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_stall_fill();
    logic [31:0] want [5];
    logic [31:0] pcs  [5];
    logic        rdy  [5];
    want = '{32'h40, 32'h40, 32'h40, 32'h44, 32'h48};
    pcs  = '{32'h40, 32'h44, 32'h48, 32'h48, 32'h48};
    rdy  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) bus.out_ready = 1'b1;
      drive(1'b1, rand_entry(pcs[i]));
      cycle();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== want[i] || bus.in_ready !== rdy[i]) begin
        errors++;
        $display("FAIL stall_fill_%0d: got valid=%b pc=%h in_ready=%b want 1 %h %b", i, bus.out_valid, bus.out_pc, bus.in_ready, want[i], rdy[i]);
      end
    end
    drive(1'b0, '0);
    cycle();
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stall_fill_drain: got %b want 0", bus.out_valid); end
    checks++;
    if (bus.stall_cnt !== CNT_W'(cnt_exp(m_stall))) begin
      errors++; $display("FAIL stall_fill_cnt: got %0d want %0d", bus.stall_cnt, cnt_exp(m_stall));
    end
  endtask

  task automatic test_flush_full();
    entry_t e;
    bus.out_ready = 1'b0;
    e = rand_entry(32'h70);
    e.ctrl = 11'h7FF;
    drive(1'b1, e);
    cycle();
    drive(1'b1, rand_entry(32'h74));
    cycle();
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_prefill_full: got in_ready=%b want 0", bus.in_ready); end
    bus.flush = 1'b1;
    drive(1'b1, rand_entry(32'h80));
    cycle();
    bus.flush = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_state: got valid=%b in_ready=%b want 0 1", bus.out_valid, bus.in_ready);
    end
    checks++;
    if (bus.out_ctrl !== 11'h27F || bus.out_pc !== 32'h70) begin
      errors++; $display("FAIL flush_masked_hold: got ctrl=%h pc=%h want 27f 00000070", bus.out_ctrl, bus.out_pc);
    end
    checks++;
    if (bus.flush_cnt !== CNT_W'(cnt_exp(m_flush))) begin
      errors++; $display("FAIL flush_cnt: got %0d want %0d", bus.flush_cnt, cnt_exp(m_flush));
    end
    drive(1'b0, '0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.out_pc === 32'h80) begin
        errors++; $display("FAIL flush_no_leak_%0d: got valid=%b pc=%h want valid=0", i, bus.out_valid, bus.out_pc);
      end
    end
  endtask

  task automatic test_bubble_mask();
    entry_t e;
    bus.out_ready = 1'b1;
    e = rand_entry(32'h90);
    e.ctrl = 11'h7FF;
    drive(1'b1, e);
    cycle();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_ctrl !== 11'h7FF) begin
      errors++; $display("FAIL bubble_live: got valid=%b ctrl=%h want 1 7ff", bus.out_valid, bus.out_ctrl);
    end
    drive(1'b0, '0);
    cycle();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_ctrl !== 11'h27F) begin
      errors++; $display("FAIL bubble_mask: got valid=%b ctrl=%h want 0 27f", bus.out_valid, bus.out_ctrl);
    end
  endtask

  task automatic test_counter_sat();
    int want;
`ifdef ID_EX_PERF_CNT_EN
    want = CMAX;
`else
    want = 0;
`endif
    bus.out_ready = 1'b0;
    drive(1'b1, rand_entry(32'hA0));
    cycle();
    drive(1'b0, '0);
    for (int i = 0; i < 20; i++) cycle();
    checks++;
    if (bus.stall_cnt !== CNT_W'(want)) begin errors++; $display("FAIL stall_sat: got %0d want %0d", bus.stall_cnt, want); end
    cycle();
    checks++;
    if (bus.stall_cnt !== CNT_W'(want) || bus.out_pc !== 32'hA0) begin
      errors++; $display("FAIL stall_sat_hold: got cnt=%0d pc=%h want %0d 000000a0", bus.stall_cnt, bus.out_pc, want);
    end
    bus.out_ready = 1'b1;
    cycle();
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.flush     = ($urandom_range(0, 15) == 0);
      drive(($urandom_range(0, 3) != 0), rand_entry($urandom));
      cycle();
      checks++;
      if (bus.out_valid !== (q.size() > 0) || bus.in_ready !== (q.size() < 2)) begin
        errors++; bad++;
        if (bad < 10) $display("FAIL rand_hs_%0d: got valid=%b in_ready=%b want %b %b", i, bus.out_valid, bus.in_ready, q.size() > 0, q.size() < 2);
      end
      checks++;
      if (observed() !== expected()) begin
        errors++; bad++;
        if (bad < 10) $display("FAIL rand_payload_%0d: got %h want %h", i, observed(), expected());
      end
      checks++;
      if (bus.stall_cnt !== CNT_W'(cnt_exp(m_stall)) || bus.bubble_cnt !== CNT_W'(cnt_exp(m_bubble)) ||
          bus.flush_cnt !== CNT_W'(cnt_exp(m_flush))) begin
        errors++; bad++;
        if (bad < 10) $display("FAIL rand_cnt_%0d: got %0d/%0d/%0d want %0d/%0d/%0d", i, bus.stall_cnt, bus.bubble_cnt,
                               bus.flush_cnt, cnt_exp(m_stall), cnt_exp(m_bubble), cnt_exp(m_flush));
      end
    end
    bus.flush = 1'b0;
  endtask

  initial begin
    clk      = 1'b0;
    rst      = 1'b1;
    checks   = 0;
    errors   = 0;
    last_m   = '0;
    m_stall  = 0;
    m_bubble = 0;
    m_flush  = 0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, '0);
    test_reset();
    test_streaming();
    test_stall_fill();
    test_flush_full();
    test_bubble_mask();
    test_counter_sat();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
